if_fetch_unit: RTL
==================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, address of the first fetched instruction after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, instruction_out value whenever busywait is high.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 stall  input  1  hazard-unit hold; PC must not advance.
REQ-006 branch_jump_signal  input  1  redirect request from EX.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_read  output  1  instruction-memory read request.
REQ-009 imem_address  output  32  instruction-memory read address.
REQ-010 imem_readdata  input  32  instruction word, valid when imem_read=1 and imem_busywait=0.
REQ-011 imem_busywait  input  1  memory not ready; address must stay stable while high.
REQ-012 pc_out  output  32  PC of the instruction on instruction_out.
REQ-013 pc_4_out  output  32  pc_out+4.
REQ-014 instruction_out  output  32  fetched instruction to the IF/ID register.
REQ-015 busywait  output  1  high when the IF/ID register must not capture this cycle.

Function
REQ-016 FSM states: WAIT (reset release, one cycle, imem_read=0), FETCH (normal fetch), DROP (discard in-flight read after a redirect).
REQ-017 Transitions: WAIT->FETCH unconditionally. FETCH->DROP on branch_jump_signal=1 with imem_busywait=1. DROP->FETCH on imem_busywait=0. All other cases hold the state.
REQ-018 imem_address=pc. imem_read=1 in FETCH and DROP, 0 in WAIT and during reset.
REQ-019 pc_4_out=pc+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-020 In FETCH with imem_busywait=0, stall=0 and branch_jump_signal=0: pc<=pc+4 at the next edge.
REQ-021 In FETCH with branch_jump_signal=1 and imem_busywait=0: pc<={branch_target[31:2],2'b00}; stall is ignored (redirect has priority).
REQ-022 In FETCH with branch_jump_signal=1 and imem_busywait=1: redirect_pc<={branch_target[31:2],2'b00}; pc is unchanged; go to DROP.
REQ-023 In DROP, a further branch_jump_signal=1 overwrites redirect_pc (latest wins). When imem_busywait=0: pc<=redirect_pc, state<=FETCH, and the returned word is discarded.
REQ-024 busywait=1 when state!=FETCH, imem_busywait=1, stall=1, or branch_jump_signal=1; otherwise 0.
REQ-025 When busywait=0: instruction_out=imem_readdata, pc_out=pc. When busywait=1: instruction_out=NOP_INSTR, pc_out=pc.
REQ-026 Fetch latency: 0 cycles beyond the memory; with imem_busywait=0 continuously, one instruction is delivered per cycle.
REQ-027 A stall with imem_busywait=0 re-reads the same pc every cycle and has no side effects.

Reset
REQ-028 reset=0 immediately forces pc=RESET_PC, redirect_pc=RESET_PC, state=WAIT, and imem_read=0, without waiting for a clock edge.
REQ-029 Reset asserted mid-request (FETCH or DROP) abandons the request. No redirect survives reset.
REQ-030 The first request after reset release is issued in the cycle after WAIT, at RESET_PC.

Structure
REQ-031 The FSM state encoding and the NOP constant shall live in the shared package riscv_pipeline_pkg.
REQ-032 The block is flat with no sub-module. The pc+4 adder and the FSM are inline.

Verification
REQ-033 Reset release, imem_busywait=0 -> imem_address sequence 0,0,4,8,C; busywait=1 only in the WAIT cycle.
REQ-034 At pc=0x10, imem_busywait=1 for 3 cycles -> pc holds 0x10, busywait=1, instruction_out=0x13; then 0x10's word delivered and pc goes to 0x14.
REQ-035 At pc=0x20 with imem_busywait=1, branch to 0x101 -> DROP; returned word discarded; next request at 0x100.
REQ-036 In DROP, second branch to 0x200 before memory ready -> next request at 0x200, not the first target.
REQ-037 stall=1 and branch_jump_signal=1 together at pc=0x40, target 0x80, memory ready -> pc=0x80 next cycle.
REQ-038 reset=0 pulsed mid-DROP between clock edges -> imem_read=0 and pc=0 immediately; restart at 0x0.

Source files
------------

// File: rtl/riscv_pipeline_pkg.sv
// Shared definitions for the RISC-V pipeline: fetch FSM encoding and
// instruction-stream constants.
package riscv_pipeline_pkg;

    // Fetch unit control states.
    //   ST_WAIT  : one idle cycle after reset release, no memory request.
    //   ST_FETCH : normal sequential fetch.
    //   ST_DROP  : a redirect arrived while a read was in flight; the word
    //              returned for that read is thrown away.
    typedef enum logic [1:0] {
        ST_WAIT  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DROP  = 2'b10
    } fetch_state_e;

    // addi x0, x0, 0 -- bubble injected into IF/ID when fetch cannot deliver.
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Instructions are word aligned; low two bits of a target are ignored.
    localparam logic [31:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    localparam logic [31:0] PC_STEP = 32'd4;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues instruction-memory reads,
// handles redirects that arrive while a read is still pending, and feeds
// the IF/ID register (with a NOP bubble whenever it cannot deliver).
module if_fetch_unit
    import riscv_pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_jump_signal,
    input  logic [31:0] branch_target,
    output logic        imem_read,
    output logic [31:0] imem_address,
    input  logic [31:0] imem_readdata,
    input  logic        imem_busywait,
    output logic [31:0] pc_out,
    output logic [31:0] pc_4_out,
    output logic [31:0] instruction_out,
    output logic        busywait
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  redirect_pc_q;
    logic         imem_read_q;

    logic [31:0]  pc_plus4;
    logic [31:0]  target_aligned;

    assign pc_plus4       = pc_q + PC_STEP;
    assign target_aligned = align_pc(branch_target);

    // Fetch FSM: state, PC, pending redirect and the read request are all
    // registered here so reset clears every one of them asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_WAIT;
            pc_q          <= RESET_PC;
            redirect_pc_q <= RESET_PC;
            imem_read_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    state_q     <= ST_FETCH;
                    imem_read_q <= 1'b1;
                end

                ST_FETCH: begin
                    imem_read_q <= 1'b1;
                    if (branch_jump_signal) begin
                        if (imem_busywait) begin
                            // Read still pending: remember where to go and
                            // keep the address stable until memory answers.
                            redirect_pc_q <= target_aligned;
                            state_q       <= ST_DROP;
                        end else begin
                            // Redirect wins over a simultaneous stall.
                            pc_q <= target_aligned;
                        end
                    end else if (!imem_busywait && !stall) begin
                        pc_q <= pc_plus4;
                    end
                end

                ST_DROP: begin
                    imem_read_q <= 1'b1;
                    if (branch_jump_signal) begin
                        redirect_pc_q <= target_aligned;
                    end
                    if (!imem_busywait) begin
                        // A redirect in this same cycle is the newest one.
                        pc_q    <= branch_jump_signal ? target_aligned : redirect_pc_q;
                        state_q <= ST_FETCH;
                    end
                end

                default: begin
                    state_q     <= ST_WAIT;
                    pc_q        <= RESET_PC;
                    imem_read_q <= 1'b0;
                end
            endcase
        end
    end

    // IF/ID handshake: deliver the memory word only in a clean FETCH cycle.
    always_comb begin
        busywait = (state_q != ST_FETCH) || imem_busywait || stall || branch_jump_signal;
        instruction_out = busywait ? NOP_INSTR : imem_readdata;
    end

    assign imem_read    = imem_read_q;
    assign imem_address = pc_q;
    assign pc_out       = pc_q;
    assign pc_4_out     = pc_plus4;

endmodule
